toaplan2_dwnld_router: RTL

Parametrised ROM-download router for the Toaplan2 cores. It sits between the HPS ioctl byte stream and the SDRAM programming port. It replaces fixed per-game region compares with N runtime-sized regions, each with its own bank and word offset. Bytes are packed into 16-bit words, buffered in a small FIFO with full PROG_RDY handshaking, and the FIFO back-pressures the loader through IOCTL_WAIT.

---
 rtl/toaplan2_dwnld_pkg.sv | 19 +
 rtl/toaplan2_dwnld_router_if.sv | 28 ++
 rtl/toaplan2_dwnld_fifo.sv | 56 +++++
 rtl/toaplan2_dwnld_router.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/toaplan2_dwnld_pkg.sv
// rtl/toaplan2_dwnld_pkg.sv - shared constants, mask encodings and FIFO entry type for the download router
package toaplan2_dwnld_pkg;
    localparam int MAX_REGIONS = 8;
    localparam int ADDR_W      = 26;
    localparam int LEN_W       = 25;

    // PROG_MASK bit set = byte lane not written
    localparam logic [1:0] MASK_WORD = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;

    // addr is sized for the widest SDRAM; the top trims it to SDRAMW
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic [1:0]        mask;
        logic [1:0]        ba;
    } fifo_entry_t;
endpackage

// File: rtl/toaplan2_dwnld_router_if.sv
// rtl/toaplan2_dwnld_router_if.sv - ioctl byte stream and SDRAM programming port of the download router
interface toaplan2_dwnld_router_if
    import toaplan2_dwnld_pkg::*;
#(
    parameter int SDRAMW = 22
);
    logic [ADDR_W-1:0] IOCTL_ADDR;   // byte address of the stream
    logic [7:0]        IOCTL_DOUT;   // byte data
    logic              IOCTL_WR;     // byte strobe
    logic              IOCTL_RAM;    // strobes ignored while high
    logic              IOCTL_WAIT;   // loader back-pressure
    logic [SDRAMW-1:0] PROG_ADDR;    // word address
    logic [15:0]       PROG_DATA;    // word data
    logic [1:0]        PROG_MASK;    // 1 = lane not written
    logic [1:0]        PROG_BA;      // bank
    logic              PROG_WE;      // write request
    logic              PROG_RDY;     // SDRAM took the current word

    // master = loader/SDRAM side, slave = router
    modport master (
        output IOCTL_ADDR, IOCTL_DOUT, IOCTL_WR, IOCTL_RAM, PROG_RDY,
        input  IOCTL_WAIT, PROG_ADDR, PROG_DATA, PROG_MASK, PROG_BA, PROG_WE
    );
    modport slave (
        input  IOCTL_ADDR, IOCTL_DOUT, IOCTL_WR, IOCTL_RAM, PROG_RDY,
        output IOCTL_WAIT, PROG_ADDR, PROG_DATA, PROG_MASK, PROG_BA, PROG_WE
    );
endinterface

// File: rtl/toaplan2_dwnld_fifo.sv
// rtl/toaplan2_dwnld_fifo.sv - 2-write/1-read first-word fall-through word FIFO with count and drop pulse
module toaplan2_dwnld_fifo
    import toaplan2_dwnld_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,     // synchronous, active-high
    input  logic [1:0]             push_n,    // entries offered this cycle (0..2)
    input  fifo_entry_t            push_d0,   // written first
    input  fifo_entry_t            push_d1,   // written second
    input  logic                   pop_req,   // pop head if not empty
    output fifo_entry_t            head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop       // offered entries did not fit
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;
    logic [PW:0]   free;
    logic          fits;

    assign empty = (count == '0);
    assign pop   = pop_req && !empty;
    // the pop is credited before the push is judged
    assign free  = DEPTH_C - count + (PW+1)'(pop);
    assign fits  = (PW+1)'(push_n) <= free;
    assign drop  = (push_n != 2'd0) && !fits;
    assign head  = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (fits && push_n != 2'd0)
            mem[wr_ptr] <= push_d0;
        if (fits && push_n == 2'd2)
            mem[wr_ptr + 1'b1] <= push_d1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fits)
                wr_ptr <= wr_ptr + PW'(push_n);
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(fits ? push_n : 2'd0) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/toaplan2_dwnld_router.sv
// rtl/toaplan2_dwnld_router.sv - ROM-download router: region decode, byte packing, FIFO, optional DWNLD_CSUM_EN checksums
module toaplan2_dwnld_router
    import toaplan2_dwnld_pkg::*;
#(
    parameter int                        REGIONS     = 4,
    parameter int                        SDRAMW      = 22,
    parameter int                        HDR_BYTES   = 1,
    parameter int                        FIFO_DEPTH  = 8,
    parameter logic [REGIONS*2-1:0]      REGION_BA   = '0,
    parameter logic [REGIONS*SDRAMW-1:0] REGION_OFFS = '0
) (
    input  logic                     CLK,
    input  logic                     RESET,        // synchronous, active-high
    input  logic                     DOWNLOADING,  // download window
    input  logic [REGIONS*LEN_W-1:0] REGION_LEN,   // byte length per region
    toaplan2_dwnld_router_if.slave   bus,          // ioctl stream in, PROG port out
    output logic                     DWNLD_BUSY,   // download or drain in progress
    output logic                     OVF,          // sticky overflow
    output logic [7:0]               GAME,         // header byte 0
    output logic [REGIONS*16-1:0]    CSUM          // per-region byte sums
);
    localparam int BASE_W = ADDR_W + 3;  // sum of eight 25-bit lengths never wraps
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [BASE_W-1:0] base_nxt [REGIONS+1];
    logic [BASE_W-1:0] base_r   [REGIONS+1];

    always_comb begin
        logic [BASE_W-1:0] acc;
        acc         = BASE_W'(HDR_BYTES);
        base_nxt[0] = acc;
        for (int i = 0; i < REGIONS; i++) begin
            acc           = acc + BASE_W'(REGION_LEN[i*LEN_W +: LEN_W]);
            base_nxt[i+1] = acc;
        end
    end

    always_ff @(posedge CLK)
        base_r <= base_nxt;

    logic [BASE_W-1:0] addr_ext;
    logic              accepted, is_hdr, hit, lane;
    logic [2:0]        reg_sel;
    logic [LEN_W-1:0]  local_off;
    logic [SDRAMW-1:0] word_sel;
    logic [1:0]        ba_sel;

    assign addr_ext = BASE_W'(bus.IOCTL_ADDR);
    assign accepted = bus.IOCTL_WR && !bus.IOCTL_RAM;
    assign is_hdr   = addr_ext < BASE_W'(HDR_BYTES);
    assign lane     = local_off[0];

    // scanned high to low so the lowest matching region wins
    always_comb begin
        hit       = 1'b0;
        reg_sel   = '0;
        local_off = '0;
        word_sel  = '0;
        ba_sel    = '0;
        for (int i = REGIONS-1; i >= 0; i--) begin
            if (addr_ext >= base_r[i] && addr_ext < base_r[i+1]) begin
                hit       = 1'b1;
                reg_sel   = 3'(i);
                local_off = LEN_W'(addr_ext - base_r[i]);
                word_sel  = REGION_OFFS[i*SDRAMW +: SDRAMW] + SDRAMW'(local_off[LEN_W-1:1]);
                ba_sel    = REGION_BA[i*2 +: 2];
            end
        end
    end

    logic              pend_vld;
    logic [SDRAMW-1:0] pend_word;
    logic [1:0]        pend_ba;
    logic [2:0]        pend_reg;
    logic [7:0]        pend_byte;
    logic              dl_q, fall_q;
    logic              data_strobe, odd_push, completes, flush;

    assign data_strobe = accepted && hit;
    assign odd_push    = data_strobe && lane;
    assign completes   = odd_push && pend_vld && pend_word == word_sel
                         && pend_ba == ba_sel && pend_reg == reg_sel;
    // any strobe that does not finish the pending word evicts it
    assign flush       = pend_vld && ((accepted && !completes) || fall_q);

    fifo_entry_t flush_e, data_e, push_d0, push_d1;
    logic [1:0]  push_n;

    always_comb begin
        flush_e.addr = ADDR_W'(pend_word);
        flush_e.data = {pend_byte, pend_byte};
        flush_e.mask = MASK_LO;
        flush_e.ba   = pend_ba;
        data_e.addr  = ADDR_W'(word_sel);
        data_e.data  = completes ? {bus.IOCTL_DOUT, pend_byte} : {bus.IOCTL_DOUT, bus.IOCTL_DOUT};
        data_e.mask  = completes ? MASK_WORD : MASK_HI;
        data_e.ba    = ba_sel;
        push_n       = {1'b0, flush} + {1'b0, odd_push};
        push_d0      = flush ? flush_e : data_e;
        push_d1      = data_e;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_vld  <= 1'b0;
            pend_word <= '0;
            pend_ba   <= '0;
            pend_reg  <= '0;
            pend_byte <= '0;
            dl_q      <= 1'b0;
            fall_q    <= 1'b0;
            GAME      <= '0;
        end else begin
            dl_q   <= DOWNLOADING;
            fall_q <= dl_q && !DOWNLOADING;
            if (data_strobe && !lane) begin
                pend_vld  <= 1'b1;
                pend_word <= word_sel;
                pend_ba   <= ba_sel;
                pend_reg  <= reg_sel;
                pend_byte <= bus.IOCTL_DOUT;
            end else if (completes || flush) begin
                pend_vld <= 1'b0;
            end
            if (accepted && is_hdr && bus.IOCTL_ADDR == '0)
                GAME <= bus.IOCTL_DOUT;
        end
    end

    fifo_entry_t   head;
    logic          fifo_empty, fifo_drop;
    logic [CW-1:0] fifo_count;

    toaplan2_dwnld_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_n  (push_n),
        .push_d0 (push_d0),
        .push_d1 (push_d1),
        .pop_req (bus.PROG_RDY),
        .head    (head),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .drop    (fifo_drop)
    );

    always_ff @(posedge CLK) begin
        if (RESET)
            OVF <= 1'b0;
        else if (fifo_drop)
            OVF <= 1'b1;
    end

    // stale RAM contents never reach the port while the FIFO is empty
    assign bus.PROG_WE   = !fifo_empty;
    assign bus.PROG_ADDR = fifo_empty ? '0 : head.addr[SDRAMW-1:0];
    assign bus.PROG_DATA = fifo_empty ? '0 : head.data;
    assign bus.PROG_MASK = fifo_empty ? '0 : head.mask;
    assign bus.PROG_BA   = fifo_empty ? '0 : head.ba;

    logic unused_addr_hi;
    assign unused_addr_hi = |head.addr;

    // a pending byte may still turn into two pushes, so it reserves one more slot
    assign bus.IOCTL_WAIT = (fifo_count >= CW'(FIFO_DEPTH-2))
                            || (pend_vld && fifo_count >= CW'(FIFO_DEPTH-3));
    assign DWNLD_BUSY     = RESET ? DOWNLOADING : (DOWNLOADING || !fifo_empty || pend_vld);

`ifdef DWNLD_CSUM_EN
    logic [15:0] csum_r [REGIONS];

    always_ff @(posedge CLK) begin
        for (int i = 0; i < REGIONS; i++) begin
            if (RESET || (DOWNLOADING && !dl_q))
                csum_r[i] <= '0;
            else if (data_strobe && reg_sel == 3'(i))
                csum_r[i] <= csum_r[i] + 16'(bus.IOCTL_DOUT);
        end
    end

    always_comb begin
        CSUM = '0;
        for (int i = 0; i < REGIONS; i++)
            CSUM[i*16 +: 16] = csum_r[i];
    end
`else
    assign CSUM = '0;
`endif
endmodule
